// File: rtl/arm_code_emitter.sv
// -----------------------------------------------------------------------------
// arm_code_emitter
//   Downstream stage of the bytecode-to-ARM translator. Takes one packet per
//   translated JVM opcode (up to MAX_WORDS 32-bit ARM words plus a count) and
//   serialises it into the ARM instruction memory, one word per cycle, at a
//   running write pointer. Reports program length, overflow and end-of-program.
//
//   Optional feature macro: EMIT_CHECKSUM_EN
//     defined   -> checksum = XOR of every word written since reset
//     undefined -> no checksum register, checksum tied to 32'h0
//
// Ports
//   clk              clock, rising edge
//   reset            synchronous, active-high
//   in_valid         packet offered
//   in_ready         block can accept a packet (IDLE only)
//   in_instructions  packet slots, slot i = [32*i +: 32], slot 0 written first
//   in_quantity      number of valid slots (clamped to MAX_WORDS)
//   flush            end of program, one-cycle pulse
//   mem_we           instruction-memory write strobe
//   mem_addr         write word address
//   mem_wdata        write data
//   words_written    words committed so far (write pointer, saturates at DEPTH)
//   overflow         sticky: words dropped because memory was full
//   done             sticky: flush completed
//   checksum         XOR of written words (or 0, see macro above)
// -----------------------------------------------------------------------------
module arm_code_emitter #(
   parameter int MAX_WORDS  = 6,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [32*MAX_WORDS-1:0] in_instructions,
   input  logic [2:0]              in_quantity,
   input  logic                    flush,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [31:0]             mem_wdata,
   output logic [ADDR_WIDTH:0]     words_written,
   output logic                    overflow,
   output logic                    done,
   output logic [31:0]             checksum
);

   // Pointer value meaning "memory completely used": DEPTH = 2**ADDR_WIDTH.
   localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [2:0]          MAX_Q     = 3'(MAX_WORDS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_FULL  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [2:0]               idx_q, idx_d;
   logic [2:0]               qty_q, qty_d;
   logic [32*MAX_WORDS-1:0]  pkt_q, pkt_d;
   logic [ADDR_WIDTH:0]      wptr_q, wptr_d;
   logic                     ovf_q, ovf_d;
   logic                     done_q, done_d;
   logic                     fpend_q, fpend_d;

   logic                     accept_s;
   logic [2:0]               qclamp_s;
   logic [31:0]              slot_s;
   logic [ADDR_WIDTH:0]      wnext_s;
   logic                     last_s;
   logic                     pend_s;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         qty_q   <= 3'd0;
         pkt_q   <= '0;
         wptr_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         fpend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         qty_q   <= qty_d;
         pkt_q   <= pkt_d;
         wptr_q  <= wptr_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         fpend_q <= fpend_d;
      end
   end

   // Select the latched slot addressed by idx_q.
   always_comb begin
      slot_s = 32'h0;
      for (int i = 0; i < MAX_WORDS; i++) begin
         slot_s = (idx_q == 3'(i)) ? pkt_q[32*i +: 32] : slot_s;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      qty_d    = qty_q;
      pkt_d    = pkt_q;
      wptr_d   = wptr_q;
      ovf_d    = ovf_q;
      done_d   = done_q;
      fpend_d  = fpend_q;
      accept_s = in_valid && (state_q == S_IDLE);
      qclamp_s = (in_quantity > MAX_Q) ? MAX_Q : in_quantity;
      wnext_s  = wptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      last_s   = (idx_q == (qty_q - 3'd1));
      // A flush arriving on the final write cycle counts as pending too.
      pend_s   = fpend_q | flush;

      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               pkt_d = in_instructions;
               qty_d = qclamp_s;
               idx_d = 3'd0;
               if (qclamp_s == 3'd0) begin
                  // Empty packet: nothing to write, flush can complete now.
                  if (flush) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_WRITE;
                  fpend_d = flush;
               end
            end else if (flush) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_WRITE: begin
            wptr_d = wnext_s;
            idx_d  = idx_q + 3'd1;
            if (wnext_s == DEPTH_PTR) begin
               // Memory now full; any slots left in this packet are lost.
               state_d = S_FULL;
               ovf_d   = ovf_q | ~last_s;
               done_d  = done_q | pend_s;
               fpend_d = 1'b0;
            end else if (last_s) begin
               fpend_d = 1'b0;
               if (pend_s) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               fpend_d = pend_s;
            end
         end

         S_FULL: begin
            if (flush) begin
               done_d = 1'b1;
            end else begin
               done_d = done_q;
            end
         end

         S_DONE: begin
            state_d = S_DONE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from registered state only.
   always_comb begin
      in_ready      = (state_q == S_IDLE);
      mem_we        = (state_q == S_WRITE);
      mem_addr      = mem_we ? wptr_q[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};
      mem_wdata     = mem_we ? slot_s : 32'h0;
      words_written = wptr_q;
      overflow      = ovf_q;
      done          = done_q;
   end

`ifdef EMIT_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;

   // Fold each committed word into the running checksum.
   always_comb begin
      if (mem_we) begin
         csum_d = csum_q ^ mem_wdata;
      end else begin
         csum_d = csum_q;
      end
   end

   // Checksum register.
   always_ff @(posedge clk) begin
      if (reset) begin
         csum_q <= 32'h0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum = csum_q;
`else
   assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_arm_code_emitter.sv
// -----------------------------------------------------------------------------
// tb_arm_code_emitter
//   Self-checking bench: a cycle table for the basic packet flows plus
//   hand-written sequences for overflow, flush, mid-write reset and clamping.
//   A second instance with ADDR_WIDTH=2 covers the memory-full case.
// -----------------------------------------------------------------------------
module tb_arm_code_emitter;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [191:0] in_instructions;
   logic [2:0]   in_quantity;
   logic         flush;

   logic         rdy, we, ovf, dn;
   logic [9:0]   addr;
   logic [31:0]  wdata, cs;
   logic [10:0]  ww;

   logic         s_rdy, s_we, s_ovf, s_dn;
   logic [1:0]   s_addr;
   logic [31:0]  s_wdata, s_cs;
   logic [2:0]   s_ww;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   arm_code_emitter dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy),
      .in_instructions(in_instructions), .in_quantity(in_quantity), .flush(flush),
      .mem_we(we), .mem_addr(addr), .mem_wdata(wdata), .words_written(ww),
      .overflow(ovf), .done(dn), .checksum(cs)
   );

   arm_code_emitter #(.MAX_WORDS(6), .ADDR_WIDTH(2)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_rdy),
      .in_instructions(in_instructions), .in_quantity(in_quantity), .flush(flush),
      .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata), .words_written(s_ww),
      .overflow(s_ovf), .done(s_dn), .checksum(s_cs)
   );

   typedef struct {
      logic        rst;
      logic        vld;
      logic [2:0]  qty;
      logic        fl;
      logic [31:0] s0;
      logic [31:0] s1;
      logic        e_we;
      logic [9:0]  e_addr;
      logic [31:0] e_data;
      logic        e_rdy;
      logic [10:0] e_ww;
      logic        e_done;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] q, input logic f);
      in_valid    = v;
      in_quantity = q;
      flush       = f;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 3'd0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_cs;
      logic [31:0] d [6];

      reset = 1'b1;
      in_instructions = '0;
      drive(1'b0, 3'd0, 1'b0);

      //          rst   vld   qty   fl    s0            s1            we    addr   data          rdy   ww      done  ovf
      vecs[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 11'd0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 3'd2, 1'b0, 32'hE3A01001, 32'hE92D0002, 1'b1, 10'd0, 32'hE3A01001, 1'b0, 11'd0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        32'h0,        1'b1, 10'd1, 32'hE92D0002, 1'b0, 11'd1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 11'd2, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 11'd0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 3'd0, 1'b0, 32'h11111111, 32'h22222222, 1'b0, 10'd0, 32'h0,        1'b1, 11'd0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 3'd1, 1'b0, 32'hE8BD0001, 32'h0,        1'b1, 10'd0, 32'hE8BD0001, 1'b0, 11'd0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 11'd1, 1'b0, 1'b0};

`ifdef EMIT_CHECKSUM_EN
      exp_cs = 32'h0A8D1003;
`else
      exp_cs = 32'h0;
`endif

      // Scenarios 1 and 2: one record per clock edge.
      for (int i = 0; i < 8; i++) begin
         reset = vecs[i].rst;
         drive(vecs[i].vld, vecs[i].qty, vecs[i].fl);
         in_instructions = {128'h0, vecs[i].s1, vecs[i].s0};
         tick();
         chk($sformatf("v%0d mem_we", i),   32'(we),    32'(vecs[i].e_we));
         chk($sformatf("v%0d mem_addr", i), 32'(addr),  32'(vecs[i].e_addr));
         chk($sformatf("v%0d wdata", i),    wdata,      vecs[i].e_data);
         chk($sformatf("v%0d in_ready", i), 32'(rdy),   32'(vecs[i].e_rdy));
         chk($sformatf("v%0d words", i),    32'(ww),    32'(vecs[i].e_ww));
         chk($sformatf("v%0d done", i),     32'(dn),    32'(vecs[i].e_done));
         chk($sformatf("v%0d overflow", i), 32'(ovf),   32'(vecs[i].e_ovf));
         if (i == 3) chk("checksum scen1", cs, exp_cs);
      end

      // Scenario 3: depth-4 instance, q=3 then q=2 -> fifth word dropped.
      do_reset();
      chk("small reset ready", 32'(s_rdy), 32'd1);
      in_instructions = {96'h0, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
      drive(1'b1, 3'd3, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("small p1 we%0d", k),   32'(s_we),   32'd1);
         chk($sformatf("small p1 addr%0d", k), 32'(s_addr), 32'(k));
         tick();
      end
      chk("small p1 ready", 32'(s_rdy), 32'd1);
      in_instructions = {128'h0, 32'hB1B1B1B1, 32'hB0B0B0B0};
      drive(1'b1, 3'd2, 1'b0);
      tick();
      drive(1'b1, 3'd1, 1'b0);
      chk("small p2 addr3", 32'(s_addr), 32'd3);
      chk("small p2 data3", s_wdata, 32'hB0B0B0B0);
      tick();
      chk("small full we", 32'(s_we), 32'd0);
      chk("small overflow", 32'(s_ovf), 32'd1);
      chk("small words", 32'(s_ww), 32'd4);
      chk("small full ready", 32'(s_rdy), 32'd0);
      tick();
      tick();
      chk("small full ready late", 32'(s_rdy), 32'd0);
      chk("small full we late", 32'(s_we), 32'd0);
      drive(1'b0, 3'd0, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      chk("small full flush done", 32'(s_dn), 32'd1);
      chk("small full flush ready", 32'(s_rdy), 32'd0);
      do_reset();
      chk("small ovf cleared", 32'(s_ovf), 32'd0);
      chk("small ready after reset", 32'(s_rdy), 32'd1);

      // Scenario 4: flush during the 2nd write cycle of a q=4 packet.
      do_reset();
      in_instructions = {64'h0, 32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
      drive(1'b1, 3'd4, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      chk("flush w0 data", wdata, 32'hC0C0C0C0);
      tick();
      chk("flush w1 data", wdata, 32'hC1C1C1C1);
      drive(1'b0, 3'd0, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      chk("flush w2 data", wdata, 32'hC2C2C2C2);
      tick();
      chk("flush w3 addr", 32'(addr), 32'd3);
      chk("flush w3 data", wdata, 32'hC3C3C3C3);
      chk("flush not done yet", 32'(dn), 32'd0);
      tick();
      chk("flush done", 32'(dn), 32'd1);
      chk("flush done we", 32'(we), 32'd0);
      chk("flush words", 32'(ww), 32'd4);
      drive(1'b1, 3'd1, 1'b0);
      tick();
      tick();
      chk("flush ready stays 0", 32'(rdy), 32'd0);
      chk("flush no write after", 32'(we), 32'd0);

      // Scenario 5: reset during the 2nd write of a q=5 packet.
      do_reset();
      drive(1'b1, 3'd5, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      tick();
      chk("rst mid we", 32'(we), 32'd1);
      chk("rst mid addr", 32'(addr), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst abort we", 32'(we), 32'd0);
      chk("rst abort words", 32'(ww), 32'd0);
      chk("rst abort ready", 32'(rdy), 32'd1);
      chk("rst abort checksum", cs, 32'h0);

      // Quantity 7 clamps to 6 slots; then flush from IDLE.
      d = '{32'hD0000000, 32'hD1000001, 32'hD2000002, 32'hD3000003, 32'hD4000004, 32'hD5000005};
      in_instructions = {d[5], d[4], d[3], d[2], d[1], d[0]};
      drive(1'b1, 3'd7, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("clamp we%0d", k),   32'(we),   32'd1);
         chk($sformatf("clamp addr%0d", k), 32'(addr), 32'(k));
         chk($sformatf("clamp data%0d", k), wdata,     d[k]);
         tick();
      end
      chk("clamp ready", 32'(rdy), 32'd1);
      chk("clamp words", 32'(ww), 32'd6);
      chk("clamp we end", 32'(we), 32'd0);
      drive(1'b0, 3'd0, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      chk("idle flush done", 32'(dn), 32'd1);
      chk("idle flush ready", 32'(rdy), 32'd0);

      // Flush together with an accepted q=1 packet.
      do_reset();
      in_instructions = {160'h0, 32'hE1A00000};
      drive(1'b1, 3'd1, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      chk("accflush we", 32'(we), 32'd1);
      chk("accflush data", wdata, 32'hE1A00000);
      chk("accflush not done", 32'(dn), 32'd0);
      tick();
      chk("accflush done", 32'(dn), 32'd1);
      chk("accflush words", 32'(ww), 32'd1);
      chk("accflush ready", 32'(rdy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
